// File: rtl/stopwatch_pkg.sv
// +------------------------------------------------------------------+
// | stopwatch_pkg                                                    |
// | Shared state encoding, mode encoding and clock defaults for the  |
// | stopwatch controller.                                            |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic c_MODE_STOPWATCH = 1'b0;
    localparam logic c_MODE_TIMER     = 1'b1;

    localparam int unsigned c_DEF_CLK_HZ  = 100_000_000;
    localparam int unsigned c_DEF_TICK_HZ = 100;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// +------------------------------------------------------------------+
// | tick_prescaler                                                   |
// | Modulo-DIV counter; tick flags the last count of each period.    |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned c_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_W'(1);
        end
    end

    assign tick = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// +------------------------------------------------------------------+
// | stopwatch_ctrl                                                   |
// | Run/pause/clear/mode control for a 6-digit stopwatch/timer.      |
// | Optional lap freeze enabled by defining STOPWATCH_LAP_EN.        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ      = c_DEF_CLK_HZ,
    parameter int unsigned TICK_HZ     = c_DEF_TICK_HZ,
    parameter int unsigned ALARM_TICKS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_clear,
    input  logic btn_mode,
    input  logic btn_lap,
    input  logic count_zero,
    input  logic count_max,
    output logic cnt_ena,
    output logic cnt_clr,
    output logic cnt_load,
    output logic cnt_down,
    output logic mode,
    output logic running,
    output logic alarm,
    output logic lap_hold
);

    localparam int unsigned c_DIV      = CLK_HZ / TICK_HZ;
    localparam int unsigned c_AW       = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [c_AW-1:0] c_ALARM_LAST = c_AW'(ALARM_TICKS - 1);
    localparam logic            c_ALARM_EN   = (ALARM_TICKS != 0);

    state_t          r_state;
    logic            r_mode;
    logic            r_cnt_ena;
    logic            r_cnt_clr;
    logic            r_cnt_load;
    logic            r_running;
    logic            r_alarm;
    logic [c_AW-1:0] r_alarm_cnt;

    logic w_tick;
    logic w_sat;
    logic w_to_done;
    logic w_pre_run;
    logic w_pre_clr;

    // End of count: timer reaching zero, or stopwatch about to overflow 999999
    assign w_sat     = (r_mode == c_MODE_TIMER) ? count_zero : (w_tick && count_max);
    assign w_to_done = (r_state == ST_RUN) && !btn_start && w_sat;
    // The prescaler restarts on DONE entry so the alarm lasts exactly ALARM_TICKS periods
    assign w_pre_run = ((r_state == ST_RUN) && !btn_start && !w_sat) ||
                       ((r_state == ST_DONE) && r_alarm);
    assign w_pre_clr = (r_state == ST_IDLE) || w_to_done;

    tick_prescaler #(
        .DIV (c_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (w_pre_run),
        .clr  (w_pre_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= c_MODE_STOPWATCH;
            r_cnt_ena   <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_cnt_load  <= 1'b0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_cnt_ena  <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_cnt_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (btn_clear) begin
                        r_cnt_clr  <= (r_mode == c_MODE_STOPWATCH);
                        r_cnt_load <= (r_mode == c_MODE_TIMER);
                    end else if (btn_start) begin
                        if (!((r_mode == c_MODE_TIMER) && count_zero)) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end else if (btn_mode) begin
                        r_mode     <= ~r_mode;
                        r_cnt_clr  <= (r_mode == c_MODE_TIMER);
                        r_cnt_load <= (r_mode == c_MODE_STOPWATCH);
                    end
                end
                ST_RUN: begin
                    if (btn_start) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_sat) begin
                        r_state     <= ST_DONE;
                        r_running   <= 1'b0;
                        r_alarm     <= (r_mode == c_MODE_TIMER) && c_ALARM_EN;
                        r_alarm_cnt <= '0;
                    end else begin
                        r_cnt_ena <= w_tick;
                    end
                end
                ST_PAUSE: begin
                    if (btn_clear) begin
                        r_state    <= ST_IDLE;
                        r_cnt_clr  <= (r_mode == c_MODE_STOPWATCH);
                        r_cnt_load <= (r_mode == c_MODE_TIMER);
                    end else if (btn_start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (btn_clear) begin
                        r_state    <= ST_IDLE;
                        r_alarm    <= 1'b0;
                        r_cnt_clr  <= (r_mode == c_MODE_STOPWATCH);
                        r_cnt_load <= (r_mode == c_MODE_TIMER);
                    end else if (btn_start) begin
                        r_alarm <= 1'b0;
                    end else if (r_alarm && w_tick) begin
                        if (r_alarm_cnt == c_ALARM_LAST) begin
                            r_alarm <= 1'b0;
                        end else begin
                            r_alarm_cnt <= r_alarm_cnt + c_AW'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_alarm   <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic r_lap_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_hold <= 1'b0;
        end else if ((btn_clear && (r_state != ST_RUN)) || w_to_done) begin
            r_lap_hold <= 1'b0;
        end else if ((r_state == ST_RUN) && !btn_start && btn_lap &&
                     (r_mode == c_MODE_STOPWATCH)) begin
            r_lap_hold <= ~r_lap_hold;
        end
    end

    assign lap_hold = r_lap_hold;
`else
    logic w_unused_lap;
    assign w_unused_lap = btn_lap;
    assign lap_hold     = 1'b0;
`endif

    assign cnt_ena  = r_cnt_ena;
    assign cnt_clr  = r_cnt_clr;
    assign cnt_load = r_cnt_load;
    assign cnt_down = r_mode;
    assign mode     = r_mode;
    assign running  = r_running;
    assign alarm    = r_alarm;

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, SHALL be the system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, SHALL be the least-significant-digit count rate in Hz (hundredths).
REQ-003 Parameter ALARM_TICKS, default 300, SHALL be the alarm duration in ticks.
REQ-004 Port clk  in  1 SHALL be the single clock; all logic is rising-edge.
REQ-005 Port rst  in  1 SHALL be the asynchronous, active-high reset.
REQ-006 Port btn_start  in  1 SHALL be a one-cycle pulse that toggles run/pause.
REQ-007 Port btn_clear  in  1 SHALL be a one-cycle clear pulse.
REQ-008 Port btn_mode  in  1 SHALL be a one-cycle mode-toggle pulse.
REQ-009 Port btn_lap  in  1 SHALL be a one-cycle lap pulse.
REQ-010 Port count_zero  in  1 SHALL indicate all six digits equal 0.
REQ-011 Port count_max  in  1 SHALL indicate all six digits equal 9.
REQ-012 Port cnt_ena  out  1 SHALL be the one-cycle enable to digit 0 of the cascade.
REQ-013 Ports cnt_clr / cnt_load  out  1 SHALL be one-cycle pulses: clear to 000000 / load timer preset.
REQ-014 Ports cnt_down, mode, running, alarm, lap_hold  out  1 SHALL give: count direction, 0=stopwatch/1=timer, state==RUN, alarm active, display frozen.

Function
REQ-015 States SHALL be IDLE, RUN, PAUSE, DONE.
REQ-016 Prescaler SHALL count 0..DIV-1 (DIV=CLK_HZ/TICK_HZ) only in RUN; tick = (prescaler==DIV-1); phase held in PAUSE; zeroed in IDLE.
REQ-017 cnt_ena SHALL be registered: high the cycle after a tick in RUN, never outside RUN.
REQ-018 IDLE + btn_start -> RUN next cycle, except timer mode with count_zero=1 (stay IDLE).
REQ-019 RUN + btn_start -> PAUSE; PAUSE + btn_start -> RUN.
REQ-020 Stopwatch: tick while count_max=1 -> DONE, no cnt_ena (saturate at 999999).
REQ-021 Timer: count_zero=1 in RUN -> DONE; alarm=1 for ALARM_TICKS ticks (prescaler runs in DONE) or until btn_clear/btn_start.
REQ-022 btn_clear in IDLE/PAUSE/DONE -> IDLE, one-cycle cnt_clr (stopwatch) or cnt_load (timer); ignored in RUN.
REQ-023 btn_mode SHALL act only in IDLE: toggle mode, then one cycle cnt_clr or cnt_load per new mode; cnt_down = mode.
REQ-024 Simultaneous pulses: btn_clear beats btn_start beats btn_mode/btn_lap.
REQ-025 All button responses SHALL appear one cycle after the pulse.

Reset
REQ-026 rst SHALL force IDLE, mode=0, prescaler=0, alarm timer=0 and every output 0 immediately, including mid-RUN.

Configuration
REQ-027 With STOPWATCH_LAP_EN defined, btn_lap in stopwatch RUN SHALL toggle lap_hold (counting continues); lap_hold cleared on btn_clear and leaving RUN via DONE.
REQ-028 Without STOPWATCH_LAP_EN, btn_lap SHALL be ignored and lap_hold tied 0.

Structure
REQ-029 State enum, mode encoding and default CLK_HZ/TICK_HZ SHALL live in package stopwatch_pkg.
REQ-030 Prescaler SHALL be sub-module tick_prescaler (parameter DIV; ports clk, rst, run, clr, tick).

Verification (CLK_HZ=1000, TICK_HZ=100, DIV=10, ALARM_TICKS=3)
REQ-031 Reset, btn_start -> running=1 next cycle; cnt_ena pulses every 10 cycles, first 10 cycles after the RUN entry.
REQ-032 Pause after 4 prescaler counts, resume -> next cnt_ena 6 cycles later.
REQ-033 Stopwatch, count_max=1 at tick -> DONE, no cnt_ena, running=0.
REQ-034 Timer, count_zero rises in RUN -> alarm=1 for 30 cycles; btn_clear -> IDLE + cnt_load pulse.
REQ-035 btn_start+btn_clear same cycle in PAUSE -> IDLE; rst mid-RUN -> all outputs 0 asynchronously.
REQ-036 With STOPWATCH_LAP_EN, btn_lap in RUN -> lap_hold=1 while cnt_ena continues; second btn_lap -> lap_hold=0.
